// File: rtl/btn_pkg.sv
// Shared definitions for the button debounce / auto-repeat controller.
// Holds the per-channel FSM state encoding and the default timing constants
// used as parameter defaults by btn_repeat_chan and btn_repeat_ctrl.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2,
        ST_REPEAT    = 2'd3
    } btn_state_e;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_DEB_CYC    = 2500;
    localparam int DEF_RPT_DELAY  = 5000000;
    localparam int DEF_RPT_PERIOD = 2500000;
    localparam int DEF_CNT_W      = 25;

endpackage

// File: rtl/btn_repeat_chan.sv
// One button channel: 2-flop synchroniser, press debounce, release debounce
// and auto-repeat timer.
// Ports:
//   clk_i     clock, rising edge
//   reset_i   synchronous active-high reset
//   btn_i     raw asynchronous button level
//   rpt_en_i  auto-repeat enable, sampled every cycle
//   level_o   debounced button state
//   pulse_o   one-cycle strobe on accepted press and on each repeat
//   state_o   current FSM state (debug visibility)
module btn_repeat_chan
    import btn_pkg::*;
#(
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_i,
    input  logic       rpt_en_i,
    output logic       level_o,
    output logic       pulse_o,
    output logic [1:0] state_o
);

    // Counters stop one short of their limit: the sample that would reach the
    // limit is the one that triggers the event, so pulses land exactly on time.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             sync1_q;
    logic             sync2_q;
    logic             en_q;
    logic             level_q;
    logic             pulse_q;
    btn_state_e       state_q;
    logic [CNT_W-1:0] deb_cnt_q;
    logic [CNT_W-1:0] rel_cnt_q;
    logic [CNT_W-1:0] rpt_cnt_q;
    logic [CNT_W-1:0] rpt_last;

    // First repeat waits the long delay, later ones the short period.
    assign rpt_last = (state_q == ST_HELD) ? DLY_LAST : PER_LAST;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            en_q      <= 1'b0;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            state_q   <= ST_IDLE;
            deb_cnt_q <= '0;
            rel_cnt_q <= '0;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            en_q    <= rpt_en_i;
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_PRESS_DEB: begin
                    if (sync2_q) begin
                        if (deb_cnt_q >= DEB_LAST) begin
                            state_q   <= ST_HELD;
                            level_q   <= 1'b1;
                            pulse_q   <= 1'b1;
                            deb_cnt_q <= '0;
                            rel_cnt_q <= '0;
                            rpt_cnt_q <= '0;
                        end else begin
                            state_q   <= ST_PRESS_DEB;
                            deb_cnt_q <= sat_inc(deb_cnt_q);
                        end
                    end else begin
                        state_q   <= ST_IDLE;
                        deb_cnt_q <= '0;
                    end
                end
                ST_HELD, ST_REPEAT: begin
                    if (!sync2_q && rel_cnt_q >= DEB_LAST) begin
                        // Release accepted; it overrides any repeat due now.
                        state_q   <= ST_IDLE;
                        level_q   <= 1'b0;
                        rel_cnt_q <= '0;
                        rpt_cnt_q <= '0;
                    end else begin
                        rel_cnt_q <= sync2_q ? '0 : sat_inc(rel_cnt_q);
                        if (!rpt_en_i) begin
                            rpt_cnt_q <= '0;
                            state_q   <= ST_HELD;
                        end else if (!en_q) begin
                            // Enable just rose: this edge is time zero of a
                            // fresh full delay, like the press pulse edge.
                            rpt_cnt_q <= '0;
                        end else if (rpt_cnt_q >= rpt_last) begin
                            pulse_q   <= 1'b1;
                            rpt_cnt_q <= '0;
                            state_q   <= ST_REPEAT;
                        end else begin
                            rpt_cnt_q <= sat_inc(rpt_cnt_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;
    assign state_o = state_q;

endmodule

// File: rtl/btn_repeat_ctrl.sv
// Multi-channel button debounce and auto-repeat controller.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   btn_in     raw asynchronous button levels, active-high
//   rpt_en     per-channel auto-repeat enable
//   btn_level  debounced button states
//   btn_pulse  per-channel press / repeat strobes
//   btn_any    OR of btn_pulse in the same cycle
//   dbg_state_o  packed per-channel FSM states, channel i at [2*i +: 2]
module btn_repeat_ctrl
    import btn_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int DEB_CYC    = DEF_DEB_CYC,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   btn_in,
    input  logic [N_CH-1:0]   rpt_en,
    output logic [N_CH-1:0]   btn_level,
    output logic [N_CH-1:0]   btn_pulse,
    output logic              btn_any,
    output logic [2*N_CH-1:0] dbg_state_o
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        btn_repeat_chan #(
            .DEB_CYC    (DEB_CYC),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk_i    (clk),
            .reset_i  (reset),
            .btn_i    (btn_in[i]),
            .rpt_en_i (rpt_en[i]),
            .level_o  (btn_level[i]),
            .pulse_o  (btn_pulse[i]),
            .state_o  (dbg_state_o[2*i +: 2])
        );
    end

    assign btn_any = |btn_pulse;

endmodule

// File: tb/tb_btn_repeat_ctrl.sv
// Bench for btn_repeat_ctrl with N_CH=4, DEB_CYC=4, RPT_DELAY=10, RPT_PERIOD=3.
// Time t counts rising edges after reset release; t=0 is the first edge that
// samples reset low. Inputs for edge t are driven on the preceding falling edge.
module tb_btn_repeat_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] rpt_en;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic       btn_any;
    logic [7:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Entry: {edge time[7:0], expected pulse mask[3:0]}
    logic [11:0] exp_q[$];

    btn_repeat_ctrl #(
        .N_CH       (4),
        .DEB_CYC    (4),
        .RPT_DELAY  (10),
        .RPT_PERIOD (3),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .rpt_en      (rpt_en),
        .btn_level   (btn_level),
        .btn_pulse   (btn_pulse),
        .btn_any     (btn_any),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int t, input logic [3:0] m);
        logic [7:0] tt;
        tt = t[7:0];
        exp_q.push_back({tt, m});
    endtask

    // Expected pulse schedules derived from the timing rules:
    // press pulse at t0+5, first repeat 10 later, then every 3.
    task automatic load_expect(input int sc);
        exp_q.delete();
        case (sc)
            1: begin
                push_exp(15, 4'b1101); push_exp(25, 4'b1100); push_exp(28, 4'b0100);
                push_exp(31, 4'b0100); push_exp(34, 4'b0100); push_exp(37, 4'b0100);
                push_exp(40, 4'b1100); push_exp(43, 4'b1100); push_exp(46, 4'b1000);
                push_exp(49, 4'b1000); push_exp(52, 4'b1000); push_exp(55, 4'b1000);
                push_exp(58, 4'b1000);
            end
            2: begin
                push_exp(15, 4'b1111); push_exp(25, 4'b0111); push_exp(28, 4'b0111);
                push_exp(31, 4'b0111); push_exp(34, 4'b0111); push_exp(37, 4'b0111);
                push_exp(40, 4'b0011); push_exp(43, 4'b0011); push_exp(46, 4'b0011);
                push_exp(49, 4'b0011);
            end
            default: begin
                push_exp(15, 4'b0001); push_exp(27, 4'b0011); push_exp(37, 4'b0001);
                push_exp(40, 4'b0001);
            end
        endcase
    endtask

    task automatic level_expect(input int sc, input int t, output bit has, output logic [3:0] v);
        has = 1'b1;
        v   = 4'b0000;
        case (sc)
            1: case (t)
                14: v = 4'b0000;
                15: v = 4'b1101;
                20: v = 4'b1101;
                44: v = 4'b1101;
                45: v = 4'b1001;
                60: v = 4'b1001;
                default: has = 1'b0;
            endcase
            2: case (t)
                15: v = 4'b1111;
                18: v = 4'b1111;
                19: v = 4'b0111;
                22: v = 4'b0111;
                34: v = 4'b0111;
                39: v = 4'b0111;
                40: v = 4'b0011;
                50: v = 4'b0011;
                default: has = 1'b0;
            endcase
            default: case (t)
                19: v = 4'b0001;
                20: v = 4'b0000;
                21: v = 4'b0000;
                26: v = 4'b0000;
                27: v = 4'b0011;
                40: v = 4'b0011;
                default: has = 1'b0;
            endcase
        endcase
    endtask

    // Driver: input pattern for edge t of scenario sc
    task automatic stim(input int sc, input int t,
                        output logic [3:0] b, output logic [3:0] e, output logic r);
        r = 1'b0;
        case (sc)
            1: begin
                b[0] = (t >= 10);
                b[1] = (t >= 10 && t < 13);
                b[2] = (t >= 10 && t < 40);
                b[3] = (t >= 10);
                e    = {!(t >= 26 && t < 30), 1'b1, 1'b0, 1'b0};
            end
            2: begin
                b[0] = (t >= 10 && !(t == 20 || t == 21));
                b[1] = (t >= 10 && !(t >= 30 && t < 33));
                b[2] = (t >= 10 && t < 35);
                b[3] = (t >= 10 && t < 14);
                e    = 4'b0111;
            end
            default: begin
                b[0] = (t >= 10);
                b[1] = (t >= 17);
                b[2] = 1'b0;
                b[3] = 1'b0;
                e    = 4'b0001;
                r    = (t == 20 || t == 21);
            end
        endcase
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset  = 1'b1;
        btn_in = '0;
        rpt_en = '0;
        repeat (3) @(posedge clk);
    endtask

    // Scoreboard step for edge t
    task automatic check_cycle(input int sc, input int t);
        logic [11:0] got;
        logic [11:0] e;
        logic [3:0]  lv;
        logic [7:0]  tt;
        bit          has;
        tt  = t[7:0];
        got = {tt, btn_pulse};
        if (exp_q.size() > 0 && exp_q[0][11:4] == tt) begin
            e = exp_q.pop_front();
            check($sformatf("pulse s%0d t%0d", sc, t), 32'(got), 32'(e));
            check($sformatf("any s%0d t%0d", sc, t), 32'(btn_any), 32'(|e[3:0]));
        end else if (btn_pulse != 4'b0000 || btn_any) begin
            check($sformatf("spurious_pulse s%0d t%0d", sc, t), {27'd0, btn_any, btn_pulse}, 32'd0);
        end
        level_expect(sc, t, has, lv);
        if (has) check($sformatf("level s%0d t%0d", sc, t), 32'(btn_level), 32'(lv));
    endtask

    task automatic run_scenario(input int sc, input int t_end);
        logic [3:0] b;
        logic [3:0] e;
        logic       r;
        apply_reset();
        load_expect(sc);
        for (int t = 0; t <= t_end; t++) begin
            @(negedge clk);
            stim(sc, t, b, e, r);
            btn_in = b;
            rpt_en = e;
            reset  = r;
            @(posedge clk);
            #1;
            check_cycle(sc, t);
        end
        check($sformatf("queue_drained s%0d", sc), exp_q.size(), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = '0;
        rpt_en = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_level", 32'(btn_level), 32'd0);
        check("reset_pulse", 32'(btn_pulse), 32'd0);
        check("reset_any",   32'(btn_any),   32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        run_scenario(1, 60);
        run_scenario(2, 50);
        run_scenario(3, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
